// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Owns the single port of a DSIZE x 2**ASIZE synchronous RAM. The RAM has a
// one-cycle registered read. Two requesters (A, B) share the port through a
// round-robin arbiter, and the block grants at most one access per cycle.
// Read data returns two cycles after the grant. After reset (optional), or on
// clr_start, a zero-fill sweep writes 0 to every word. This is needed because
// the RAM's own reset only clears its output register.
//
// Ports
//   clk, rstn              clock, synchronous active-low reset
//   clr_start / busy       sweep request pulse / sweep in progress
//   req_x, we_x, addr_x,   per-requester access (x = a, b); fields are held
//   wdata_x                until gnt_x
//   gnt_x                  combinational grant, same cycle as req_x
//   rvalid_x, rdata_x      read return pulse / registered data (held)
//   ram_addr, ram_din,     RAM port drive
//   ram_we, ram_en
//   ram_dout               RAM registered read data
module ram_port_arbiter #(
  parameter int DSIZE          = 8,
  parameter int ASIZE          = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_start,
  output logic             busy,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             we_a,
  input  logic             we_b,
  input  logic [ASIZE-1:0] addr_a,
  input  logic [ASIZE-1:0] addr_b,
  input  logic [DSIZE-1:0] wdata_a,
  input  logic [DSIZE-1:0] wdata_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             rvalid_a,
  output logic             rvalid_b,
  output logic [DSIZE-1:0] rdata_a,
  output logic [DSIZE-1:0] rdata_b,
  output logic [ASIZE-1:0] ram_addr,
  output logic [DSIZE-1:0] ram_din,
  output logic             ram_we,
  output logic             ram_en,
  input  logic [DSIZE-1:0] ram_dout
);

  localparam int STAGES = 2;
  localparam logic [ASIZE-1:0] CLR_LAST = '1;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;

  state_t           state, state_nxt;
  logic             prio;          // 0: A preferred, 1: B preferred
  logic [ASIZE-1:0] clr_cnt;
  logic             rd_issue;      // granted read this cycle
  logic [STAGES:1]  vld_pipe;      // read tag valid per stage
  logic [STAGES:1]  own_pipe;      // read tag owner per stage, 1 = B

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    ram_we    = 1'b0;
    ram_en    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    case (state)
      ST_RESET: begin
        busy      = (CLEAR_ON_RESET != 0);
        state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      end
      ST_CLEAR: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
        if (clr_cnt == CLR_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        gnt_a = req_a & (~req_b | ~prio);
        gnt_b = req_b & (~req_a |  prio);
        if (gnt_a) begin
          ram_we   = we_a;
          ram_en   = ~we_a;
          ram_addr = addr_a;
          ram_din  = we_a ? wdata_a : '0;
        end else if (gnt_b) begin
          ram_we   = we_b;
          ram_en   = ~we_b;
          ram_addr = addr_b;
          ram_din  = we_b ? wdata_b : '0;
        end
        // Arbitration above still happens in the cycle clr_start is seen.
        if (clr_start) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  assign rd_issue = (gnt_a & ~we_a) | (gnt_b & ~we_b);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio     <= 1'b0;
      clr_cnt  <= '0;
      vld_pipe <= '0;
      own_pipe <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      rdata_a  <= '0;
      rdata_b  <= '0;
    end else begin
      // Pointer moves to whoever lost; idle cycles leave it alone.
      if (gnt_a)      prio <= 1'b1;
      else if (gnt_b) prio <= 1'b0;

      if (state == ST_RUN && clr_start)
        clr_cnt <= '0;
      else if (state == ST_CLEAR && clr_cnt != CLR_LAST)
        clr_cnt <= clr_cnt + 1'b1;

      // Tag stage 1 lines up with ram_dout; stage 2 is the registered return.
      // In-flight reads finish even across a CLEAR entry.
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_issue};
      own_pipe <= {own_pipe[STAGES-1:1], gnt_b};
      rvalid_a <= vld_pipe[1] & ~own_pipe[1];
      rvalid_b <= vld_pipe[1] &  own_pipe[1];
      if (vld_pipe[1] && !own_pipe[1]) rdata_a <= ram_dout;
      if (vld_pipe[1] &&  own_pipe[1]) rdata_b <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter (ASIZE=4, DSIZE=8, CLEAR_ON_RESET=1) with a
// behavioural RAM whose contents start non-zero. The bench drives inputs just
// after the rising edge and samples outputs on the falling edge.
module tb_ram_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, clr_start, busy;
  logic          req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b, ram_addr;
  logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b, ram_din, ram_dout;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b, ram_we, ram_en;

  ram_port_arbiter #(.DSIZE(DW), .ASIZE(AW), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rstn(rstn), .clr_start(clr_start), .busy(busy),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_en(ram_en), .ram_dout(ram_dout)
  );

  // RAM model: reset clears only the output register.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hFF;
  always @(posedge clk) begin
    if (!rstn) ram_dout <= '0;
    else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      if (ram_en) ram_dout <= mem[ram_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_gnt"},    {gnt_a, gnt_b}, 0);
    chk({tag, "_rvalid"}, {rvalid_a, rvalid_b}, 0);
    chk({tag, "_rdata_a"}, rdata_a, 0);
    chk({tag, "_rdata_b"}, rdata_b, 0);
    chk({tag, "_ram_ctl"}, {ram_we, ram_en}, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_din"}, ram_din, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  // Entered in the first CLEAR cycle. Checks every sweep cycle and the sweep
  // length, and logs the first rvalid of each requester (sweep index and data).
  // With hold_a, the caller holds req_a as a read of an address. The task
  // then expects the grant right after busy falls, and zero read data two
  // cycles later.
  task automatic sweep(input bit hold_a, input int pulse_at,
                       output int rva_at, output logic [7:0] rva_d,
                       output int rvb_at, output logic [7:0] rvb_d);
    int cnt;
    cnt = 0; rva_at = -1; rvb_at = -1; rva_d = 0; rvb_d = 0;
    for (int i = 0; i < 40; i++) begin
      clr_start = (cnt == pulse_at);
      @(negedge clk);
      if (!busy) break;
      if (rvalid_a && rva_at < 0) begin rva_at = cnt; rva_d = rdata_a; end
      if (rvalid_b && rvb_at < 0) begin rvb_at = cnt; rvb_d = rdata_b; end
      chk("sweep_ctl", {ram_we, ram_en}, 2'b10);
      chk("sweep_addr", ram_addr, cnt);
      chk("sweep_din", ram_din, 0);
      chk("sweep_gnt", {gnt_a, gnt_b}, 0);
      cnt++;
      step();
    end
    clr_start = 1'b0;
    chk("sweep_len", cnt, 16);
    if (hold_a) begin
      chk("first_gnt_a", gnt_a, 1);
      step();
      req_a = 1'b0;
      @(negedge clk);
      chk("post_sweep_rv_early", rvalid_a, 0);
      step();
      @(negedge clk);
      chk("post_sweep_rvalid", rvalid_a, 1);
      chk("post_sweep_zero", rdata_a, 0);
      step();
    end
  endtask

  typedef struct {
    logic ra; logic wa; logic [3:0] aa; logic [7:0] da;
    logic rb; logic wb; logic [3:0] ab; logic [7:0] db;
    logic ga; logic gb; logic va; logic vb; logic [7:0] rda; logic [7:0] rdb;
  } vec_t;

  function automatic vec_t v(logic ra, logic wa, logic [3:0] aa, logic [7:0] da,
                             logic rb, logic wb, logic [3:0] ab, logic [7:0] db,
                             logic ga, logic gb, logic va, logic vb,
                             logic [7:0] rda, logic [7:0] rdb);
    vec_t t;
    t.ra = ra; t.wa = wa; t.aa = aa; t.da = da;
    t.rb = rb; t.wb = wb; t.ab = ab; t.db = db;
    t.ga = ga; t.gb = gb; t.va = va; t.vb = vb; t.rda = rda; t.rdb = rdb;
    return t;
  endfunction

  vec_t tbl[$];
  int ra_at, rb_at;
  logic [7:0] ra_d, rb_d;
  logic e_we, e_en;
  logic [3:0] e_addr;
  logic [7:0] e_din;

  initial begin
    //                A: req we addr data     B: req we addr data     gA gB vA vB rdA   rdB
    tbl.push_back(v(1, 1, 4'd3, 8'hA5,  0, 0, 4'd0, 8'h00,  1, 0, 0, 0, 8'h00, 8'h00)); // c0
    tbl.push_back(v(1, 0, 4'd3, 8'h00,  0, 0, 4'd0, 8'h00,  1, 0, 0, 0, 8'h00, 8'h00)); // c1
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  0, 0, 4'd0, 8'h00,  0, 0, 0, 0, 8'h00, 8'h00));
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  0, 0, 4'd0, 8'h00,  0, 0, 1, 0, 8'hA5, 8'h00)); // c3
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  1, 1, 4'd1, 8'h11,  0, 1, 0, 0, 8'hA5, 8'h00));
    tbl.push_back(v(1, 1, 4'd2, 8'h22,  0, 0, 4'd0, 8'h00,  1, 0, 0, 0, 8'hA5, 8'h00));
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  1, 1, 4'd5, 8'h55,  0, 1, 0, 0, 8'hA5, 8'h00)); // prio->A
    for (int i = 0; i < 6; i++)   // both held: A,B,A,B,A,B
      tbl.push_back(v(1, 1, 4'd6, 8'h66, 1, 1, 4'd7, 8'h77, (i % 2) == 0, (i % 2) == 1,
                      0, 0, 8'hA5, 8'h00));
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  1, 0, 4'd7, 8'h00,  0, 1, 0, 0, 8'hA5, 8'h00)); // c13
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  1, 0, 4'd7, 8'h00,  0, 1, 0, 0, 8'hA5, 8'h00));
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  1, 0, 4'd7, 8'h00,  0, 1, 0, 1, 8'hA5, 8'h77));
    tbl.push_back(v(1, 0, 4'd6, 8'h00,  1, 0, 4'd5, 8'h00,  1, 0, 0, 1, 8'hA5, 8'h77)); // A joins
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  1, 0, 4'd5, 8'h00,  0, 1, 0, 1, 8'hA5, 8'h77));
    tbl.push_back(v(1, 0, 4'd1, 8'h00,  0, 0, 4'd0, 8'h00,  1, 0, 1, 0, 8'h66, 8'h77)); // c18
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  1, 0, 4'd2, 8'h00,  0, 1, 0, 1, 8'h66, 8'h55));
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  0, 0, 4'd0, 8'h00,  0, 0, 1, 0, 8'h11, 8'h55));
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  0, 0, 4'd0, 8'h00,  0, 0, 0, 1, 8'h11, 8'h22));
    tbl.push_back(v(0, 0, 4'd0, 8'h00,  0, 0, 4'd0, 8'h00,  0, 0, 0, 0, 8'h11, 8'h22));

    // Reset with req_a held as a read of address 0.
    rstn = 1'b0; clr_start = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check_reset("reset");
    step();
    sweep(1, -1, ra_at, ra_d, rb_at, rb_d);

    // Table-driven vectors.
    foreach (tbl[i]) begin
      req_a = tbl[i].ra; we_a = tbl[i].wa; addr_a = tbl[i].aa; wdata_a = tbl[i].da;
      req_b = tbl[i].rb; we_b = tbl[i].wb; addr_b = tbl[i].ab; wdata_b = tbl[i].db;
      e_we   = (tbl[i].ga & tbl[i].wa) | (tbl[i].gb & tbl[i].wb);
      e_en   = (tbl[i].ga & ~tbl[i].wa) | (tbl[i].gb & ~tbl[i].wb);
      e_addr = tbl[i].ga ? tbl[i].aa : (tbl[i].gb ? tbl[i].ab : 4'd0);
      e_din  = !e_we ? 8'h00 : (tbl[i].ga ? tbl[i].da : tbl[i].db);
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {gnt_a, gnt_b}, {tbl[i].ga, tbl[i].gb});
      chk($sformatf("v%0d_rvalid", i), {rvalid_a, rvalid_b}, {tbl[i].va, tbl[i].vb});
      chk($sformatf("v%0d_rdata_a", i), rdata_a, tbl[i].rda);
      chk($sformatf("v%0d_rdata_b", i), rdata_b, tbl[i].rdb);
      chk($sformatf("v%0d_ram_ctl", i), {ram_we, ram_en}, {e_we, e_en});
      chk($sformatf("v%0d_ram_addr", i), ram_addr, e_addr);
      if (!e_en) chk($sformatf("v%0d_ram_din", i), ram_din, e_din);
      step();
    end
    req_a = 1'b0; req_b = 1'b0;

    // Reset pulse with reads in flight: no rvalid, reset values, new sweep.
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd3;
    @(negedge clk);
    chk("mr_gnt", gnt_a, 1);
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1; req_a = 1'b0;
    @(negedge clk);
    check_reset("midreset");
    step();
    sweep(0, -1, ra_at, ra_d, rb_at, rb_d);
    chk("mr_no_rvalid_a", ra_at, -1);
    chk("mr_no_rvalid_b", rb_at, -1);
    step();

    // clr_start mid-stream; a second clr_start during the sweep is ignored.
    req_a = 1'b1; we_a = 1'b1; addr_a = 4'd3; wdata_a = 8'h3C;
    @(negedge clk);
    chk("cs_wr_gnt", gnt_a, 1);
    step();
    we_a = 1'b0;
    @(negedge clk);
    chk("cs_rd_gnt_a", gnt_a, 1);
    step();
    req_a = 1'b0; req_b = 1'b1; we_b = 1'b0; addr_b = 4'd3; clr_start = 1'b1;
    @(negedge clk);
    chk("cs_rd_gnt_b", gnt_b, 1);
    chk("cs_busy_low", busy, 0);
    step();
    req_b = 1'b0; req_a = 1'b1; we_a = 1'b0; addr_a = 4'd3;
    sweep(1, 5, ra_at, ra_d, rb_at, rb_d);
    chk("cs_rva_at", ra_at, 0);
    chk("cs_rva_data", ra_d, 8'h3C);
    chk("cs_rvb_at", rb_at, 1);
    chk("cs_rvb_data", rb_d, 8'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
